// File: rtl/huff_encoder.sv
// Builds a Huffman code table from up to MAX_STRING_LENGTH weighted bytes, one merge or encode step per edge.
// done rises 2 + 2*(U-1) edges after reset release; inputs are sampled once and then ignored until reset.
module huff_encoder #(
  parameter int MAX_STRING_LENGTH = 3,
  parameter int MAX_CHAR_COUNT    = 3
) (
  input  logic                                               clk,
  input  logic                                               reset,
  input  logic [0:MAX_STRING_LENGTH-1][7:0]                  data_in,
  input  logic [0:MAX_STRING_LENGTH-1][2:0]                  freq_in,
  output logic [0:MAX_CHAR_COUNT-1][MAX_CHAR_COUNT-1:0]      encoded_value,
  output logic [0:MAX_CHAR_COUNT-1][MAX_CHAR_COUNT-1:0]      encoded_mask,
  output logic [0:MAX_CHAR_COUNT-1][7:0]                     character,
  output logic                                               done
);
  localparam int L  = MAX_STRING_LENGTH;
  localparam int C  = MAX_CHAR_COUNT;
  localparam int N  = 2 * C - 1;
  localparam int NW = $clog2(N + 1);
  localparam int WW = 3 + $clog2(L);
  localparam int UW = $clog2(C + 1);

  typedef enum logic [2:0] {IDLE, INIT, MERGE, ENCODE, DONE} state_t;

  state_t                r_state;
  logic [0:L-1][7:0]     r_din;
  logic [0:L-1][2:0]     r_fin;
  logic [7:0]            r_chr  [C];
  logic [WW-1:0]         r_w    [N];
  logic [N-1:0]          r_live;
  logic [NW-1:0]         r_c0   [N];
  logic [NW-1:0]         r_c1   [N];
  logic [C-1:0]          r_code [N];
  logic [UW-1:0]         r_len  [N];
  logic [UW-1:0]         r_nu;
  logic [NW-1:0]         r_nn;
  logic [NW-1:0]         r_k;
  logic [NW-1:0]         r_cnt;

  logic [7:0]            w_lchr [C];
  logic [WW-1:0]         w_lw   [C];
  logic [UW-1:0]         w_nu;
  logic [NW-1:0]         w_m1;
  logic [NW-1:0]         w_m2;
  logic [C-1:0]          w_code_nx [N];
  logic [UW-1:0]         w_len_nx  [N];

  function automatic logic [C-1:0] len2mask(input logic [UW-1:0] len);
    logic [C-1:0] m;
    for (int b = 0; b < C; b++) m[b] = (b < int'(len));
    return m;
  endfunction

  // Leaf list: first appearance order, duplicates folded, overflow symbols dropped.
  always_comb begin : leaves
    logic hit;
    w_nu = '0;
    hit  = 1'b0;
    for (int j = 0; j < C; j++) begin
      w_lchr[j] = '0;
      w_lw[j]   = '0;
    end
    for (int s = 0; s < L; s++) begin
      if (r_din[s] != 8'h00 && r_fin[s] != 3'd0) begin
        hit = 1'b0;
        for (int j = 0; j < C; j++) begin
          if (UW'(j) < w_nu && w_lchr[j] == r_din[s]) begin
            w_lw[j] = w_lw[j] + WW'(r_fin[s]);
            hit     = 1'b1;
          end
        end
        if (!hit && w_nu < UW'(C)) begin
          w_lchr[w_nu] = r_din[s];
          w_lw[w_nu]   = WW'(r_fin[s]);
          w_nu         = w_nu + UW'(1);
        end
      end
    end
  end

  // Two lightest live nodes; strict compare in ascending order gives ties to the lower index.
  always_comb begin : pick
    logic          f1, f2;
    logic [WW-1:0] b1, b2;
    f1 = 1'b0; f2 = 1'b0; b1 = '0; b2 = '0;
    w_m1 = '0; w_m2 = '0;
    for (int i = 0; i < N; i++) begin
      if (r_live[i] && (!f1 || r_w[i] < b1)) begin
        f1 = 1'b1; b1 = r_w[i]; w_m1 = NW'(i);
      end
    end
    for (int i = 0; i < N; i++) begin
      if (r_live[i] && NW'(i) != w_m1 && (!f2 || r_w[i] < b2)) begin
        f2 = 1'b1; b2 = r_w[i]; w_m2 = NW'(i);
      end
    end
  end

  always_comb begin : enc
    w_code_nx = r_code;
    w_len_nx  = r_len;
    w_code_nx[r_c0[r_k]] = r_code[r_k] << 1;
    w_len_nx[r_c0[r_k]]  = r_len[r_k] + UW'(1);
    w_code_nx[r_c1[r_k]] = (r_code[r_k] << 1) | C'(1);
    w_len_nx[r_c1[r_k]]  = r_len[r_k] + UW'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= IDLE;
      encoded_value <= '0;
      encoded_mask  <= '0;
      character     <= '0;
      done          <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_din   <= data_in;
          r_fin   <= freq_in;
          r_state <= INIT;
        end
        INIT: begin
          for (int i = 0; i < N; i++) begin
            r_w[i]    <= '0;
            r_live[i] <= (i < int'(w_nu));
            r_code[i] <= '0;
            r_len[i]  <= '0;
          end
          for (int i = 0; i < C; i++) begin
            r_w[i]   <= w_lw[i];
            r_chr[i] <= w_lchr[i];
          end
          r_nu  <= w_nu;
          r_nn  <= NW'(w_nu);
          r_cnt <= NW'(w_nu) - NW'(1);
          if (w_nu >= UW'(2)) begin
            r_state <= MERGE;
          end else begin
            r_state <= DONE;
            done    <= 1'b1;
            for (int i = 0; i < C; i++) character[i] <= w_lchr[i];
          end
        end
        MERGE: begin
          r_w[r_nn]    <= r_w[w_m1] + r_w[w_m2];
          r_live[r_nn] <= 1'b1;
          r_live[w_m1] <= 1'b0;
          r_live[w_m2] <= 1'b0;
          r_c0[r_nn]   <= w_m1;
          r_c1[r_nn]   <= w_m2;
          r_nn         <= r_nn + NW'(1);
          if (r_cnt == NW'(1)) begin
            r_state <= ENCODE;
            r_k     <= r_nn;
            r_cnt   <= NW'(r_nu) - NW'(1);
          end else begin
            r_cnt <= r_cnt - NW'(1);
          end
        end
        ENCODE: begin
          r_code <= w_code_nx;
          r_len  <= w_len_nx;
          r_k    <= r_k - NW'(1);
          r_cnt  <= r_cnt - NW'(1);
          if (r_cnt == NW'(1)) begin
            r_state <= DONE;
            done    <= 1'b1;
            // Indices >= U in the node table are internal nodes, not symbols.
            for (int i = 0; i < C; i++) begin
              character[i] <= r_chr[i];
              if (i < int'(r_nu)) begin
                encoded_value[i] <= w_code_nx[i];
                encoded_mask[i]  <= len2mask(w_len_nx[i]);
              end else begin
                encoded_value[i] <= '0;
                encoded_mask[i]  <= '0;
              end
            end
          end
        end
        default: r_state <= DONE;
      endcase
    end
  end
endmodule

// File: tb/tb_huff_encoder.sv
// Directed bench for huff_encoder with hand-computed code tables.
module tb_huff_encoder;
  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [0:2][7:0]   data_in = '0;
  logic [0:2][2:0]   freq_in = '0;
  logic [0:2][2:0]   encoded_value;
  logic [0:2][2:0]   encoded_mask;
  logic [0:2][7:0]   character;
  logic              done;

  int compared = 0;
  int failed   = 0;

  huff_encoder #(.MAX_STRING_LENGTH(3), .MAX_CHAR_COUNT(3)) dut (
    .clk           (clk),
    .reset         (reset),
    .data_in       (data_in),
    .freq_in       (freq_in),
    .encoded_value (encoded_value),
    .encoded_mask  (encoded_mask),
    .character     (character),
    .done          (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic run_case(input string tag, input logic [23:0] d, input logic [8:0] f,
                          input int lat, input logic [23:0] ech,
                          input logic [8:0] ev, input logic [8:0] em);
    int n;
    @(negedge clk);
    reset   = 1'b1;
    data_in = d;
    freq_in = f;
    @(posedge clk); #1;
    chk({tag, ".rst_done"}, 64'(done), 64'(0));
    chk({tag, ".rst_char"}, 64'(character), 64'(0));
    chk({tag, ".rst_val"},  64'(encoded_value), 64'(0));
    chk({tag, ".rst_mask"}, 64'(encoded_mask), 64'(0));
    @(negedge clk);
    reset = 1'b0;
    n = 0;
    while (!done && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk({tag, ".latency"}, 64'(n), 64'(lat));
    chk({tag, ".char"}, 64'(character), 64'(ech));
    chk({tag, ".val"},  64'(encoded_value), 64'(ev));
    chk({tag, ".mask"}, 64'(encoded_mask), 64'(em));
    // Outputs must hold and ignore new inputs until the next reset.
    @(negedge clk);
    data_in = 24'h7a7978;
    freq_in = 9'h1ff;
    repeat (3) @(posedge clk);
    #1;
    chk({tag, ".hold_done"}, 64'(done), 64'(1));
    chk({tag, ".hold_char"}, 64'(character), 64'(ech));
    chk({tag, ".hold_val"},  64'(encoded_value), 64'(ev));
  endtask

  initial begin
    run_case("anu", "anu", {3'd2, 3'd3, 3'd7}, 6, "anu",
             {3'b000, 3'b001, 3'b001}, {3'b011, 3'b011, 3'b001});
    run_case("aab", "aab", {3'd1, 3'd1, 3'd1}, 4, {"a", "b", 8'h00},
             {3'b001, 3'b000, 3'b000}, {3'b001, 3'b001, 3'b000});
    run_case("abc", "abc", {3'd1, 3'd1, 3'd1}, 6, "abc",
             {3'b010, 3'b011, 3'b000}, {3'b011, 3'b011, 3'b001});
    run_case("aaa", "aaa", {3'd1, 3'd2, 3'd3}, 2, {"a", 8'h00, 8'h00},
             9'b0, 9'b0);
    run_case("empty", {8'h00, "a", "b"}, {3'd5, 3'd1, 3'd2}, 4, {"a", "b", 8'h00},
             {3'b000, 3'b001, 3'b000}, {3'b001, 3'b001, 3'b000});
    run_case("zerofreq", "xyz", {3'd0, 3'd0, 3'd0}, 2, 24'h0, 9'b0, 9'b0);

    // Reset in the middle of the merge phase of "anu".
    @(negedge clk);
    reset   = 1'b1;
    data_in = "anu";
    freq_in = {3'd2, 3'd3, 3'd7};
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("mid.busy_done", 64'(done), 64'(0));
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("mid.rst_done", 64'(done), 64'(0));
    chk("mid.rst_char", 64'(character), 64'(0));
    chk("mid.rst_mask", 64'(encoded_mask), 64'(0));
    run_case("mid_abc", "abc", {3'd1, 3'd1, 3'd1}, 6, "abc",
             {3'b010, 3'b011, 3'b000}, {3'b011, 3'b011, 3'b001});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
    $finish;
  end
endmodule

// File: doc/huff_encoder.md
Name: huff_encoder

Overview:
Builds a Huffman code table from a small set of weighted 8-bit symbols and emits one variable-length code per unique symbol.
- Sits after a symbol/frequency counter and in front of a bit-packer.
- Consumes the captured symbol list over several clock cycles using a multi-cycle FSM.
- Raises `done` once the code table is stable.

Parameters:
MAX_STRING_LENGTH, 3, number of input symbol slots L.
MAX_CHAR_COUNT, 3, maximum number of unique symbols U, and the width of each code and mask. Must be ≤ MAX_STRING_LENGTH.

Ports:
clk  in  1  single clock; all state changes on its rising edge.
reset  in  1  synchronous, active-high reset.
data_in  in  [0:L-1][7:0]  symbol slots; slot 0 is the most-significant byte; 0x00 = empty slot.
freq_in  in  [0:L-1][2:0]  weight of the matching data_in slot.
encoded_value  out  [0:MAX_CHAR_COUNT-1][MAX_CHAR_COUNT-1:0]  code for character[i], right-aligned.
encoded_mask  out  [0:MAX_CHAR_COUNT-1][MAX_CHAR_COUNT-1:0]  ones over the valid code bits (LSB-aligned run; popcount = code length).
character  out  [0:MAX_CHAR_COUNT-1][7:0]  unique symbols in first-appearance order; unused entries are 0x00.
done  out  1  high when the outputs are valid.

Behaviour:
- Reset (reset=1 at a clk edge): state becomes IDLE; encoded_value, encoded_mask, character and done all become 0. Reset has priority at any point, including mid-build; inputs are recaptured after release.
- FSM states: IDLE → INIT → MERGE → ENCODE → DONE.
- IDLE: on the first edge with reset=0, register data_in and freq_in, then go to INIT. Inputs are ignored until the next reset.
- INIT (one edge): build the leaf list.
  - Skip slots whose byte is 0x00 or whose weight is 0.
  - Merge duplicate bytes by summing their weights; the sum needs width ≥ 3+clog2(L).
  - Leaves are numbered 0..U-1 in first-appearance order (lowest slot index first).
  - If U ≥ 2 go to MERGE; otherwise go to DONE.
- MERGE (exactly U-1 edges, one merge per edge):
  - Pick the live node with the smallest weight (min1) and the next smallest (min2).
  - Ties go to the lower node index. New internal nodes take indices U, U+1, ….
  - Create a parent with weight = sum of the two; record min1 as child bit 0 and min2 as child bit 1.
  - Retire both children; the parent becomes live.
- ENCODE (exactly U-1 edges): walk internal nodes from newest (root) to oldest.
  - Root code is empty, length 0.
  - Child code = (parent code << 1) | child bit; child length = parent length + 1.
  - The first bit assigned (root side) ends up as the MSB of the code.
- DONE:
  - Drive character[i], encoded_value[i] and encoded_mask[i] for i < U; entries with i ≥ U are 0.
  - done = 1, and all outputs hold until reset.
- Outputs stay 0 in all states before DONE.
- Latency: done rises after 2 + 2·(U-1) edges from the first edge with reset low.
- U = 1: no encoding; value = 0 and mask = 0 for the single symbol, done after 2 edges.
- U = 0: all outputs 0, done after 2 edges.
- More than MAX_CHAR_COUNT unique symbols: only the first MAX_CHAR_COUNT are kept; later new symbols are dropped. Result is defined but not a valid Huffman code.
- Maximum code length is U-1, which always fits the MAX_CHAR_COUNT-bit fields.

Test Plan:
- data_in="anu", freq 2,3,7.
  - Leaves a2 n3 u7; merges: a+n=5, then 5+u.
  - Expect character = 'a','n','u'.
  - a: value 3'b000, mask 3'b011. n: value 3'b001, mask 3'b011. u: value 3'b001, mask 3'b001.
  - done after 6 edges.
- data_in="aab", freq 1,1,1.
  - a merged to weight 2, b has weight 1.
  - Expect character = 'a','b'; b = 0 and a = 1, both with mask 3'b001; done after 4 edges.
- data_in="abc", freq 1,1,1 (tie-break check).
  - a and b merge first.
  - Expect c = 3'b000 mask 3'b001; a = 3'b010 mask 3'b011; b = 3'b011 mask 3'b011.
- data_in="aaa", freq 1,2,3.
  - Expect U=1, character[0]='a', value 0, mask 0, character[1..2]=0, done after 2 edges.
- data_in={8'h00,"a","b"}, freq 5,1,2.
  - Empty slot ignored; expect character = 'a','b'; a = 0 and b = 1, both with mask 3'b001.
- Assert reset during MERGE while running "anu".
  - done and all outputs must read 0 the next edge.
  - After release with new inputs, the result must match the fresh-run values.
